// File: rtl/alu_decode_pkg.sv
// Shared types and the RV32I decode function for the ALU decode stage.
// ILLEGAL_INSN_TRAP_EN adds an illegal flag to the decoded bundle.
package alu_decode_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned AluCtrlWidth = 4;

  typedef enum logic [AluCtrlWidth-1:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluSrl  = 4'b0101,
    AluOr   = 4'b0110,
    AluAnd  = 4'b0111,
    AluSub  = 4'b1000,
    AluSra  = 4'b1101
  } alu_ctrl_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  typedef struct packed {
    logic [AluCtrlWidth-1:0] alu_ctrl;
    logic                    alu_src;
    logic                    alu_pc;
    logic [DataWidth-1:0]    imm_ext;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    branch;
    logic                    jump;
    logic [DataWidth-1:0]    pc;
`ifdef ILLEGAL_INSN_TRAP_EN
    logic                    illegal;
`endif
  } decoded_t;

  function automatic decoded_t decode(input logic [DataWidth-1:0] instr,
                                      input logic [DataWidth-1:0] pc);
    decoded_t   d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [DataWidth-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
`ifdef ILLEGAL_INSN_TRAP_EN
    logic illegal;
    illegal = 1'b0;
`endif
    d     = '0;
    d.pc  = pc;
    f7    = instr[31:25];
    f3    = instr[14:12];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    case (instr[6:0])
      OpcOp: begin
        d.alu_ctrl  = {f7[5], f3};
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
`ifdef ILLEGAL_INSN_TRAP_EN
        illegal = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                  (f7[5] && (f3 != 3'b000) && (f3 != 3'b101));
`endif
      end
      OpcOpImm: begin
        // Only SRAI may carry f7[5]; addi's imm[10] must not turn into sub.
        d.alu_ctrl  = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
        d.imm_ext   = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, instr[24:20]} : imm_i;
        d.alu_src   = 1'b1;
        d.rs1       = instr[19:15];
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
      end
      OpcLoad: begin
        d.alu_ctrl  = AluAdd;
        d.imm_ext   = imm_i;
        d.alu_src   = 1'b1;
        d.rs1       = instr[19:15];
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
        d.mem_read  = 1'b1;
      end
      OpcStore: begin
        d.alu_ctrl  = AluAdd;
        d.imm_ext   = imm_s;
        d.alu_src   = 1'b1;
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.mem_write = 1'b1;
      end
      OpcBranch: begin
        d.alu_ctrl = AluSub;
        d.imm_ext  = imm_b;
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        d.branch   = 1'b1;
      end
      OpcJalr: begin
        d.alu_ctrl  = AluAdd;
        d.imm_ext   = imm_i;
        d.alu_src   = 1'b1;
        d.rs1       = instr[19:15];
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
        d.jump      = 1'b1;
      end
      OpcJal: begin
        d.alu_ctrl  = AluAdd;
        d.imm_ext   = imm_j;
        d.alu_src   = 1'b1;
        d.alu_pc    = 1'b1;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
        d.jump      = 1'b1;
      end
      OpcAuipc: begin
        d.alu_ctrl  = AluAdd;
        d.imm_ext   = imm_u;
        d.alu_src   = 1'b1;
        d.alu_pc    = 1'b1;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
      end
      OpcLui: begin
        d.alu_ctrl  = AluAdd;
        d.imm_ext   = imm_u;
        d.alu_src   = 1'b1;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_INSN_TRAP_EN
        illegal = 1'b1;
`endif
      end
    endcase

    if (d.rd == 5'd0) d.reg_write = 1'b0;
`ifdef ILLEGAL_INSN_TRAP_EN
    if (illegal) begin
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.branch    = 1'b0;
      d.jump      = 1'b0;
    end
    d.illegal = illegal;
`endif
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_stage_if.sv
// Fetch-side and execute-side signals of the ALU decode stage.
// ILLEGAL_INSN_TRAP_EN adds the illegal output.
interface alu_ctrl_decode_stage_if;
  import alu_decode_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DataWidth-1:0]    in_instr;
  logic [DataWidth-1:0]    in_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [AluCtrlWidth-1:0] ALUCtrl;
  logic                    alu_src;
  logic                    alu_pc;
  logic [DataWidth-1:0]    imm_ext;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic [4:0]              rd;
  logic                    reg_write;
  logic                    mem_read;
  logic                    mem_write;
  logic                    branch;
  logic                    jump;
  logic [DataWidth-1:0]    pc_out;
`ifdef ILLEGAL_INSN_TRAP_EN
  logic                    illegal;
`endif

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, ALUCtrl, alu_src, alu_pc, imm_ext, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch, jump, pc_out
`ifdef ILLEGAL_INSN_TRAP_EN
  , output illegal
`endif
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, ALUCtrl, alu_src, alu_pc, imm_ext, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch, jump, pc_out
`ifdef ILLEGAL_INSN_TRAP_EN
  , input illegal
`endif
  );
endinterface

// File: rtl/decode_skid_buf.sv
// Two-entry skid buffer of decoded bundles with synchronous flush.
module decode_skid_buf
  import alu_decode_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  decoded_t in_data_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output decoded_t out_data_o
);

  decoded_t main_q, main_d, skid_q, skid_d;
  logic     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic     push, pop;

  assign push = in_valid_i && in_ready_o;
  assign pop  = main_vld_q && out_ready_i;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (pop) begin
      // Skid is older than any new input, so it refills main first.
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_d     = in_data_i;
        main_vld_d = push;
      end
    end else if (push) begin
      if (main_vld_q) begin
        skid_d     = in_data_i;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = in_data_i;
        main_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_vld_q ? main_q : '0;

endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// Registered RV32I decode stage producing ALUCtrl, immediate and control bits.
// ILLEGAL_INSN_TRAP_EN enables the illegal-instruction flag.
module alu_ctrl_decode_stage
  import alu_decode_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  alu_ctrl_decode_stage_if.slave  dif
);

  decoded_t dec, bundle;

  assign dec = decode(dif.in_instr, dif.in_pc);

  decode_skid_buf u_skid_buf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (dif.in_valid),
    .in_ready_o  (dif.in_ready),
    .in_data_i   (dec),
    .out_valid_o (dif.out_valid),
    .out_ready_i (dif.out_ready),
    .out_data_o  (bundle)
  );

  assign dif.ALUCtrl   = bundle.alu_ctrl;
  assign dif.alu_src   = bundle.alu_src;
  assign dif.alu_pc    = bundle.alu_pc;
  assign dif.imm_ext   = bundle.imm_ext;
  assign dif.rs1       = bundle.rs1;
  assign dif.rs2       = bundle.rs2;
  assign dif.rd        = bundle.rd;
  assign dif.reg_write = bundle.reg_write;
  assign dif.mem_read  = bundle.mem_read;
  assign dif.mem_write = bundle.mem_write;
  assign dif.branch    = bundle.branch;
  assign dif.jump      = bundle.jump;
  assign dif.pc_out    = bundle.pc;
`ifdef ILLEGAL_INSN_TRAP_EN
  assign dif.illegal   = bundle.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Directed self-checking bench for alu_ctrl_decode_stage.
module tb_alu_ctrl_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  alu_ctrl_decode_stage_if dif ();

  alu_ctrl_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc);
    dif.in_valid = vld;
    dif.in_instr = instr;
    dif.in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    dif.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    step();
    check_eq("rst_out_valid", {31'b0, dif.out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, dif.in_ready}, 32'd1);
    check_eq("rst_imm", dif.imm_ext, 32'd0);
    check_eq("rst_rd", {27'b0, dif.rd}, 32'd0);
    rst_n = 1'b1;

    // add x3,x1,x2
    dif.out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h100);
    step();
    check_eq("add_valid", {31'b0, dif.out_valid}, 32'd1);
    check_eq("add_ctrl", {28'b0, dif.ALUCtrl}, 32'h0);
    check_eq("add_rd", {27'b0, dif.rd}, 32'd3);
    check_eq("add_rs1", {27'b0, dif.rs1}, 32'd1);
    check_eq("add_rs2", {27'b0, dif.rs2}, 32'd2);
    check_eq("add_regw", {31'b0, dif.reg_write}, 32'd1);
    check_eq("add_src", {31'b0, dif.alu_src}, 32'd0);
    check_eq("add_pc", dif.pc_out, 32'h100);

    drive(1'b1, 32'h402081B3, 32'h104);
    step();
    check_eq("sub_ctrl", {28'b0, dif.ALUCtrl}, 32'h8);

    drive(1'b1, 32'h40335293, 32'h108);
    step();
    check_eq("srai_ctrl", {28'b0, dif.ALUCtrl}, 32'hD);
    check_eq("srai_imm", dif.imm_ext, 32'h3);
    check_eq("srai_src", {31'b0, dif.alu_src}, 32'd1);
    check_eq("srai_rs2", {27'b0, dif.rs2}, 32'd0);

    drive(1'b1, 32'hFFF00093, 32'h10C);
    step();
    check_eq("addi_ctrl", {28'b0, dif.ALUCtrl}, 32'h0);
    check_eq("addi_imm", dif.imm_ext, 32'hFFFFFFFF);

    // sw x2,8(x1)
    drive(1'b1, 32'h0020A423, 32'h110);
    step();
    check_eq("sw_memw", {31'b0, dif.mem_write}, 32'd1);
    check_eq("sw_imm", dif.imm_ext, 32'h8);
    check_eq("sw_rd", {27'b0, dif.rd}, 32'd0);
    check_eq("sw_regw", {31'b0, dif.reg_write}, 32'd0);

    drive(1'b1, 32'h0000007F, 32'h114);
    step();
    check_eq("nop_ctrl", {28'b0, dif.ALUCtrl}, 32'h0);
    check_eq("nop_regw", {31'b0, dif.reg_write}, 32'd0);
    check_eq("nop_memw", {31'b0, dif.mem_write}, 32'd0);
`ifdef ILLEGAL_INSN_TRAP_EN
    check_eq("ill_flag", {31'b0, dif.illegal}, 32'd1);
`endif

    drive(1'b0, 32'h0, 32'h0);
    step();
    check_eq("idle_valid", {31'b0, dif.out_valid}, 32'd0);

    // Stall: three offers with out_ready low for three cycles.
    dif.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200);
    step();
    check_eq("st_a_valid", {31'b0, dif.out_valid}, 32'd1);
    check_eq("st_a_rdy", {31'b0, dif.in_ready}, 32'd1);
    drive(1'b1, 32'h00200113, 32'h204);
    step();
    check_eq("st_b_rdy", {31'b0, dif.in_ready}, 32'd0);
    check_eq("st_b_hold", dif.pc_out, 32'h200);
    drive(1'b1, 32'h00300193, 32'h208);
    step();
    check_eq("st_c_rdy", {31'b0, dif.in_ready}, 32'd0);
    check_eq("st_c_hold", dif.imm_ext, 32'd1);
    dif.out_ready = 1'b1;
    step();
    check_eq("rel_b_pc", dif.pc_out, 32'h204);
    check_eq("rel_b_imm", dif.imm_ext, 32'd2);
    check_eq("rel_b_rdy", {31'b0, dif.in_ready}, 32'd1);
    step();
    check_eq("rel_c_pc", dif.pc_out, 32'h208);
    check_eq("rel_c_rd", {27'b0, dif.rd}, 32'd3);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check_eq("rel_empty", {31'b0, dif.out_valid}, 32'd0);

    // Flush with both entries full and a word offered.
    dif.out_ready = 1'b0;
    drive(1'b1, 32'h00400213, 32'h300);
    step();
    drive(1'b1, 32'h00500293, 32'h304);
    step();
    check_eq("fl_full", {31'b0, dif.in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00600313, 32'h308);
    step();
    flush = 1'b0;
    check_eq("fl_valid", {31'b0, dif.out_valid}, 32'd0);
    check_eq("fl_rdy", {31'b0, dif.in_ready}, 32'd1);
    check_eq("fl_zero", dif.pc_out, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    dif.out_ready = 1'b1;
    step();
    check_eq("fl_drop", {31'b0, dif.out_valid}, 32'd0);

    // Flush with an acceptable word offered: it must still be dropped.
    dif.out_ready = 1'b0;
    drive(1'b1, 32'h00700393, 32'h400);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h00800413, 32'h404);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_eq("fl1_valid", {31'b0, dif.out_valid}, 32'd0);
    step();
    check_eq("fl1_drop", {31'b0, dif.out_valid}, 32'd0);

    // Reset in the middle of a stall discards the entries.
    drive(1'b1, 32'h00900493, 32'h500);
    step();
    drive(1'b1, 32'h00A00513, 32'h504);
    step();
    drive(1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rs_valid", {31'b0, dif.out_valid}, 32'd0);
    check_eq("rs_rdy", {31'b0, dif.in_ready}, 32'd1);
    dif.out_ready = 1'b1;
    step();
    check_eq("rs_empty", {31'b0, dif.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
